// File: rtl/hs_fifo_sync_pkg.sv
// Shared definitions for the hs_fifo_sync capture-path FIFO: default
// parameter values, head-register refill operations and a constant
// ceil(log2) helper usable in parameter expressions.
package hs_fifo_sync_pkg;

  localparam int HS_FIFO_D_WIDTH      = 32;
  localparam int HS_FIFO_DEPTH        = 16;
  localparam int HS_FIFO_AFULL_THRESH = 12;

  // What happens to the output head register on the coming edge.
  typedef enum logic [1:0] {
    HEAD_HOLD     = 2'd0,  // head valid and not consumed: keep it
    HEAD_FROM_RAM = 2'd1,  // refill from the oldest stored word
    HEAD_FROM_SRC = 2'd2,  // storage empty: incoming word goes straight to head
    HEAD_DRAIN    = 2'd3   // nothing left to present: head becomes invalid
  } head_op_e;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int hs_clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hs_fifo_sync_if.sv
// Handshake bundle for hs_fifo_sync: upstream valid/ready/data, downstream
// valid/ready/data and the fill-level status. The slave modport is the FIFO
// side, the master modport is the surrounding logic (producer + consumer).
// Optional flush_i exists only when HS_FIFO_FLUSH_EN is defined.
interface hs_fifo_sync_if
  import hs_fifo_sync_pkg::*;
#(
  parameter int D_WIDTH = HS_FIFO_D_WIDTH,
  parameter int DEPTH   = HS_FIFO_DEPTH
);

  localparam int LVL_W = hs_clog2(DEPTH + 1);

  logic               valid_src_i;
  logic [D_WIDTH-1:0] data_src_i;
  logic               ready_src_o;
  logic               valid_dst_o;
  logic [D_WIDTH-1:0] data_dst_o;
  logic               ready_dst_i;
  logic [LVL_W-1:0]   level_o;
  logic               almost_full_o;
`ifdef HS_FIFO_FLUSH_EN
  logic               flush_i;
`endif

`ifdef HS_FIFO_FLUSH_EN
  modport slave (
    input  valid_src_i, data_src_i, ready_dst_i, flush_i,
    output ready_src_o, valid_dst_o, data_dst_o, level_o, almost_full_o
  );
  modport master (
    output valid_src_i, data_src_i, ready_dst_i, flush_i,
    input  ready_src_o, valid_dst_o, data_dst_o, level_o, almost_full_o
  );
`else
  modport slave (
    input  valid_src_i, data_src_i, ready_dst_i,
    output ready_src_o, valid_dst_o, data_dst_o, level_o, almost_full_o
  );
  modport master (
    output valid_src_i, data_src_i, ready_dst_i,
    input  ready_src_o, valid_dst_o, data_dst_o, level_o, almost_full_o
  );
`endif

endinterface

// File: rtl/hs_fifo_ram.sv
// Storage array for hs_fifo_sync: DEPTH x D_WIDTH registers, one synchronous
// write port and an asynchronous read port. Storage is deliberately not reset;
// the pointers in the top level decide which entries are meaningful.
module hs_fifo_ram
  import hs_fifo_sync_pkg::*;
#(
  parameter int D_WIDTH = HS_FIFO_D_WIDTH,
  parameter int DEPTH   = HS_FIFO_DEPTH,
  parameter int ADDR_W  = hs_clog2(HS_FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem [DEPTH];

  // Write port: store the incoming word at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read is combinational so the head register can refill in the same edge
  // that the current head is consumed.
  assign rdata = mem[raddr];

endmodule

// File: rtl/hs_fifo_sync.sv
// hs_fifo_sync: single-clock valid/ready FIFO between the pixel packer and
// the DMA writer. The output word lives in a head register (first-word
// fall-through, one cycle latency); the remaining words live in hs_fifo_ram.
// level_o counts the head plus stored words, so capacity is DEPTH in total.
// All outputs are registered; there is no combinational source->dest path.
// Optional feature macro: HS_FIFO_FLUSH_EN adds a synchronous flush_i.
module hs_fifo_sync
  import hs_fifo_sync_pkg::*;
#(
  parameter int D_WIDTH      = HS_FIFO_D_WIDTH,
  parameter int DEPTH        = HS_FIFO_DEPTH,
  parameter int AFULL_THRESH = HS_FIFO_AFULL_THRESH
) (
  input logic           clk,
  input logic           resetn,
  hs_fifo_sync_if.slave bus
);

  localparam int PTR_W = hs_clog2(DEPTH);
  localparam int LVL_W = hs_clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AFULL_LVL = LVL_W'(AFULL_THRESH);

  // Registered state
  logic [PTR_W-1:0]   wr_ptr_reg,  wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg,  rd_ptr_next;
  logic [LVL_W-1:0]   level_reg,   level_next;
  logic               head_valid_reg, head_valid_next;
  logic [D_WIDTH-1:0] head_data_reg,  head_data_next;
  logic               ready_reg,   ready_next;
  logic               afull_reg,   afull_next;

  // Datapath / control
  logic               flush;
  logic               push;
  logic               pop;
  logic               ram_empty;
  logic               ram_we;
  logic [D_WIDTH-1:0] ram_rdata;
  head_op_e           head_op;

`ifdef HS_FIFO_FLUSH_EN
  assign flush = bus.flush_i;
`else
  assign flush = 1'b0;
`endif

  assign push = bus.valid_src_i && ready_reg;
  assign pop  = head_valid_reg && bus.ready_dst_i;
  // Words in storage = level minus the one sitting in the head register.
  assign ram_empty = (level_reg == LVL_W'(head_valid_reg));

  hs_fifo_ram #(
    .D_WIDTH (D_WIDTH),
    .DEPTH   (DEPTH),
    .ADDR_W  (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_reg),
    .wdata (bus.data_src_i),
    .raddr (rd_ptr_reg),
    .rdata (ram_rdata)
  );

  // Decide how the head register is refilled this cycle.
  always_comb begin
    head_op = HEAD_HOLD;
    if (!head_valid_reg || pop) begin
      if (!ram_empty) begin
        head_op = HEAD_FROM_RAM;
      end else if (push) begin
        head_op = HEAD_FROM_SRC;
      end else begin
        head_op = HEAD_DRAIN;
      end
    end
  end

  // Next-state: pointers, level, head register and flags; flush overrides all.
  always_comb begin
    ram_we          = push && (head_op != HEAD_FROM_SRC);
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    level_next      = level_reg;
    head_valid_next = head_valid_reg;
    head_data_next  = head_data_reg;

    if (ram_we) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end

    unique case (head_op)
      HEAD_FROM_RAM: begin
        head_valid_next = 1'b1;
        head_data_next  = ram_rdata;
        rd_ptr_next     = rd_ptr_reg + PTR_W'(1);
      end
      HEAD_FROM_SRC: begin
        head_valid_next = 1'b1;
        head_data_next  = bus.data_src_i;
      end
      HEAD_DRAIN: begin
        head_valid_next = 1'b0;
      end
      default: begin
        head_valid_next = head_valid_reg;
      end
    endcase

    unique case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase

    // Flush discards any same-cycle push/pop; the head data is left as is.
    if (flush) begin
      ram_we          = 1'b0;
      wr_ptr_next     = '0;
      rd_ptr_next     = '0;
      level_next      = '0;
      head_valid_next = 1'b0;
      head_data_next  = head_data_reg;
    end

    // Flags come from the next level so full drops ready without a bubble.
    ready_next = (level_next < DEPTH_LVL);
    afull_next = (level_next >= AFULL_LVL);
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
      ready_reg      <= 1'b0;
      afull_reg      <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      level_reg      <= level_next;
      head_valid_reg <= head_valid_next;
      head_data_reg  <= head_data_next;
      ready_reg      <= ready_next;
      afull_reg      <= afull_next;
    end
  end

  assign bus.ready_src_o   = ready_reg;
  assign bus.valid_dst_o   = head_valid_reg;
  assign bus.data_dst_o    = head_data_reg;
  assign bus.level_o       = level_reg;
  assign bus.almost_full_o = afull_reg;

endmodule
